control_sequencer: RTL
======================

# control_sequencer

Hardwired fetch/decode/execute controller that sits directly upstream of `memory_system` and drives every one of its control inputs. It consumes the 5-bit `instruction` and the registered C/N/P/Z flags that `memory_system` returns. A Moore state machine sequences register-bank, ALU, MAR, MDR, IR and memory read/write strobes so that programs held in memory run one instruction at a time.

## Interface
Parameters:
- `R_PC`, 3'd0, bank address of PC
- `R_DPTR`, 3'd1, bank address of DPTR
- `R_A`, 3'd2, bank address of A
- `R_TEMP`, 3'd3, bank address of TEMP (jump target)
- `R_ACC`, 3'd4, bank address of ACC
- `OP_PASS`, 3'd0, `selop` code: ALU out = busB
- `OP_INC`, 3'd1, `selop` code: busB+1
- `OP_ADD` / `OP_SUB` / `OP_AND` / `OP_OR`, 3'd2/3'd3/3'd4/3'd5, `selop` codes: ACC op busB

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  leave IDLE and begin fetching (sampled in IDLE only)
- `instruction`  in  5  IR contents from `memory_system`
- `C`, `N`, `P`, `Z`  in  1 each  registered ALU flags
- `ir_sclr`, `mar_sclr`  out  1  synchronous clears of IR and MAR
- `enaf`  out  1  flag-register update enable
- `selop`  out  3  ALU operation
- `shamt`  out  2  shift amount, constant 2'b00
- `bank_wr_en`  out  1  register-bank write
- `busB_addr`, `busC_addr`  out  3 each  bank read / write addresses
- `ir_en`, `mar_en`, `mdr_en`  out  1 each  load enables
- `wr_rdn`  out  1  memory write (1) / read (0)
- `mdr_alu_n`  out  1  busC source: MDR (1) / ALU (0); MDR load source: memory (1) / ALU (0)
- `halted`  out  1  high in HALT
- `illegal`  out  1  one-cycle pulse on an undefined opcode
- `state_m`  out  4  current state code, for monitoring

## Operation
- States: IDLE, F0, F1, DEC, L1, L2, S1, S2, HALT. Outputs decode combinationally from the state register and `instruction`. Any output not listed for a state is 0.
- IDLE: `ir_sclr`=`mar_sclr`=1. Go to F0 when `start`=1.
- F0: busB=PC, selop=OP_PASS, `mar_en`=1. Go to F1.
- F1: `wr_rdn`=0, `ir_en`=1; also busB=PC, selop=OP_INC, busC=PC, `bank_wr_en`=1. Go to DEC.
- DEC executes by opcode, then returns to F0 unless noted:
  - 00000 NOP: no strobes.
  - 00001 LDA: busB=DPTR, OP_PASS, `mar_en`=1. Go to L1.
  - 00010 STA: busB=DPTR, OP_PASS, `mar_en`=1. Go to S1.
  - 00011/00100/00101/00110 ADD/SUB/AND/OR: busB=A, selop=matching OP, busC=ACC, `bank_wr_en`=1, `enaf`=1.
  - 00111 INCD: busB=DPTR, OP_INC, busC=DPTR, `bank_wr_en`=1; flags not updated.
  - 01000 JZ / 01001 JN: if Z (resp. N)=1, then busB=TEMP, OP_PASS, busC=PC, `bank_wr_en`=1; otherwise no strobes.
  - 11111 HALT: go to HALT.
  - Any other opcode: NOP behaviour plus `illegal`=1.
- L1: `wr_rdn`=0, `mdr_alu_n`=1, `mdr_en`=1. L2: `mdr_alu_n`=1, busC=A, `bank_wr_en`=1. L2 goes to F0.
- S1: busB=A, OP_PASS, `mdr_alu_n`=0, `mdr_en`=1. S2: `wr_rdn`=1. S2 goes to F0.
- HALT: `halted`=1, no strobes. Only `rst` exits HALT.
- `shamt` is always 2'b00. `start` is ignored outside IDLE.

## Timing
- `rst` low forces IDLE immediately, regardless of clock. Reset output values: `ir_sclr`=`mar_sclr`=1; all other outputs 0; `state_m`=IDLE code. This applies mid-instruction too: a pending STA write never issues.
- Cycles per instruction, F0 through the last state: NOP, ALU, INCD, JZ/JN (taken or not), illegal = 3; LDA, STA = 5.
- Jump conditions use the flag values present during DEC, i.e. flags from the last `enaf` instruction. An ALU op's own flag update is not visible until the next instruction.
- PC increments in F1, so a jump overwrites the incremented PC in DEC (last write wins).
- `start` held high in IDLE: exactly one transition to F0 on the first rising edge.
- `wr_rdn`=1 only in S2. `ir_en` only in F1. `mar_en` only in F0 and in DEC for LDA/STA.

## Test plan
- Reset mid-S1 (`rst` low between edges) → outputs reach reset values with no clock edge; `state_m`=IDLE; `wr_rdn` never 1.
- `start`=1 after reset, `instruction`=00011 at DEC → F0/F1/DEC in 3 cycles; DEC shows selop=OP_ADD, busB=3'd2, busC=3'd4, `bank_wr_en`=`enaf`=1.
- `instruction`=00001 → F0,F1,DEC,L1,L2; L1 shows `mdr_en`=`mdr_alu_n`=1, `wr_rdn`=0; L2 shows busC=3'd2, `bank_wr_en`=1; then F0.
- `instruction`=01000: with Z=1 → DEC shows busB=3'd3, busC=3'd0, `bank_wr_en`=1; with Z=0 → no strobes; both take 3 cycles.
- `instruction`=10110 → `illegal` high for exactly the DEC cycle, then F0.
- `instruction`=11111 → HALT with `halted`=1 held for 10 cycles regardless of `start`; `rst` low → IDLE.

Source files
------------

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Hardwired fetch/decode/execute controller for memory_system.
//                A Moore state machine walks IDLE -> F0 -> F1 -> DEC and,
//                for loads/stores, through L1/L2 or S1/S2. Every control
//                strobe of memory_system is decoded combinationally from the
//                state register (and, in DEC, from the opcode and flags).
//  Ports       : clk, rst (async, active-low), start
//                instruction[4:0], C/N/P/Z flags       -> inputs
//                ir_sclr, mar_sclr, enaf, selop[2:0], shamt[1:0],
//                bank_wr_en, busB_addr[2:0], busC_addr[2:0], ir_en, mar_en,
//                mdr_en, wr_rdn, mdr_alu_n, halted, illegal, state_m[3:0]
//  Revision    : 1.0  initial release
// ============================================================================
module control_sequencer #(
    parameter logic [2:0] R_PC    = 3'd0,
    parameter logic [2:0] R_DPTR  = 3'd1,
    parameter logic [2:0] R_A     = 3'd2,
    parameter logic [2:0] R_TEMP  = 3'd3,
    parameter logic [2:0] R_ACC   = 3'd4,
    parameter logic [2:0] OP_PASS = 3'd0,
    parameter logic [2:0] OP_INC  = 3'd1,
    parameter logic [2:0] OP_ADD  = 3'd2,
    parameter logic [2:0] OP_SUB  = 3'd3,
    parameter logic [2:0] OP_AND  = 3'd4,
    parameter logic [2:0] OP_OR   = 3'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] instruction,
    input  logic       C,
    input  logic       N,
    input  logic       P,
    input  logic       Z,
    output logic       ir_sclr,
    output logic       mar_sclr,
    output logic       enaf,
    output logic [2:0] selop,
    output logic [1:0] shamt,
    output logic       bank_wr_en,
    output logic [2:0] busB_addr,
    output logic [2:0] busC_addr,
    output logic       ir_en,
    output logic       mar_en,
    output logic       mdr_en,
    output logic       wr_rdn,
    output logic       mdr_alu_n,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state_m
);

    // Opcodes
    localparam logic [4:0] C_OPC_NOP  = 5'b00000;
    localparam logic [4:0] C_OPC_LDA  = 5'b00001;
    localparam logic [4:0] C_OPC_STA  = 5'b00010;
    localparam logic [4:0] C_OPC_ADD  = 5'b00011;
    localparam logic [4:0] C_OPC_SUB  = 5'b00100;
    localparam logic [4:0] C_OPC_AND  = 5'b00101;
    localparam logic [4:0] C_OPC_OR   = 5'b00110;
    localparam logic [4:0] C_OPC_INCD = 5'b00111;
    localparam logic [4:0] C_OPC_JZ   = 5'b01000;
    localparam logic [4:0] C_OPC_JN   = 5'b01001;
    localparam logic [4:0] C_OPC_HALT = 5'b11111;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F0   = 4'd1,
        ST_F1   = 4'd2,
        ST_DEC  = 4'd3,
        ST_L1   = 4'd4,
        ST_L2   = 4'd5,
        ST_S1   = 4'd6,
        ST_S2   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    state_t r_state;

    // Carry and parity are not consumed by any branch of this instruction set.
    logic w_unused_flags;
    assign w_unused_flags = C | P;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= start ? ST_F0 : ST_IDLE;
                ST_F0:   r_state <= ST_F1;
                ST_F1:   r_state <= ST_DEC;
                ST_DEC: begin
                    case (instruction)
                        C_OPC_LDA:  r_state <= ST_L1;
                        C_OPC_STA:  r_state <= ST_S1;
                        C_OPC_HALT: r_state <= ST_HALT;
                        default:    r_state <= ST_F0;
                    endcase
                end
                ST_L1:   r_state <= ST_L2;
                ST_L2:   r_state <= ST_F0;
                ST_S1:   r_state <= ST_S2;
                ST_S2:   r_state <= ST_F0;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode. Because it depends only on r_state (and the opcode in
    // DEC), an asynchronous reset drives the IDLE values without a clock edge.
    // ------------------------------------------------------------------------
    always_comb begin
        ir_sclr    = 1'b0;
        mar_sclr   = 1'b0;
        enaf       = 1'b0;
        selop      = OP_PASS;
        shamt      = 2'b00;
        bank_wr_en = 1'b0;
        busB_addr  = 3'd0;
        busC_addr  = 3'd0;
        ir_en      = 1'b0;
        mar_en     = 1'b0;
        mdr_en     = 1'b0;
        wr_rdn     = 1'b0;
        mdr_alu_n  = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                ir_sclr  = 1'b1;
                mar_sclr = 1'b1;
            end
            ST_F0: begin
                busB_addr = R_PC;
                selop     = OP_PASS;
                mar_en    = 1'b1;
            end
            ST_F1: begin
                // Memory read into IR overlaps with PC <- PC + 1.
                ir_en      = 1'b1;
                busB_addr  = R_PC;
                selop      = OP_INC;
                busC_addr  = R_PC;
                bank_wr_en = 1'b1;
            end
            ST_DEC: begin
                case (instruction)
                    C_OPC_NOP, C_OPC_HALT: ;
                    C_OPC_LDA, C_OPC_STA: begin
                        busB_addr = R_DPTR;
                        selop     = OP_PASS;
                        mar_en    = 1'b1;
                    end
                    C_OPC_ADD, C_OPC_SUB, C_OPC_AND, C_OPC_OR: begin
                        busB_addr  = R_A;
                        busC_addr  = R_ACC;
                        bank_wr_en = 1'b1;
                        enaf       = 1'b1;
                        case (instruction)
                            C_OPC_ADD: selop = OP_ADD;
                            C_OPC_SUB: selop = OP_SUB;
                            C_OPC_AND: selop = OP_AND;
                            default:   selop = OP_OR;
                        endcase
                    end
                    C_OPC_INCD: begin
                        busB_addr  = R_DPTR;
                        selop      = OP_INC;
                        busC_addr  = R_DPTR;
                        bank_wr_en = 1'b1;
                    end
                    C_OPC_JZ, C_OPC_JN: begin
                        // Taken jump overwrites the PC already incremented in F1.
                        if ((instruction == C_OPC_JZ) ? Z : N) begin
                            busB_addr  = R_TEMP;
                            selop      = OP_PASS;
                            busC_addr  = R_PC;
                            bank_wr_en = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            ST_L1: begin
                mdr_alu_n = 1'b1;
                mdr_en    = 1'b1;
            end
            ST_L2: begin
                mdr_alu_n  = 1'b1;
                busC_addr  = R_A;
                bank_wr_en = 1'b1;
            end
            ST_S1: begin
                busB_addr = R_A;
                selop     = OP_PASS;
                mdr_en    = 1'b1;
            end
            ST_S2: begin
                wr_rdn = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_m = r_state;

endmodule
`default_nettype wire
